result_collector: RTL and testbench

Drains the output-stationary PE array. It sits at the far end of the per-PE finish bus.
- On each PE finish pulse, the block snapshots that PE's accumulator into a per-PE holding slot.
- It then streams the N×N results out in row-major address order over a valid/ready interface, so the array can start the next tile while the previous tile is still draining.
- Address map matches the array: PE k = row·ARRAY_SIZE + col, 0 top-left, N²−1 bottom-right.

---
 rtl/result_collector_pkg.sv | 9 +
 rtl/result_slot.sv | 53 +++++
 rtl/result_collector.sv | 75 +++++++
 tb/tb_result_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Shared array geometry for the PE array, finish decider and result collector.
package result_collector_pkg;

  localparam int unsigned ARRAY_SIZE = 4;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned N2         = ARRAY_SIZE * ARRAY_SIZE;
  localparam int unsigned IDX_W      = $clog2(N2);

endpackage

// File: rtl/result_slot.sv
// One per-PE holding slot: captured accumulator, pending flag and sticky overflow.
module result_slot
  import result_collector_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_i,
  input  logic             pop_i,
  input  logic [ACC_W-1:0] data_i,
  output logic [ACC_W-1:0] data_o,
  output logic             pending_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] val_q, val_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;

  // A pop frees the slot in the same cycle, so a coincident capture refills it.
  always_comb begin
    val_d  = val_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (pop_i) begin
      pend_d = 1'b0;
    end
    if (capture_i) begin
      if (!pend_q || pop_i) begin
        val_d  = data_i;
        pend_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      val_q  <= val_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_o    = val_q;
  assign pending_o = pend_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/result_collector.sv
// Snapshots PE accumulators on finish pulses and drains them in row-major order
// over a valid/ready stream.
module result_collector
  import result_collector_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N2-1:0]         finish_i,
  input  logic [N2*ACC_W-1:0]   pe_result_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [ACC_W-1:0]      out_data_o,
  output logic [IDX_W-1:0]      out_idx_o,
  output logic                  out_last_o,
  output logic                  tile_done_o,
  output logic                  overflow_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N2 - 1);

  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             tile_done_q, tile_done_d;
  logic [ACC_W-1:0] slot_data [N2];
  logic [N2-1:0]    slot_pend;
  logic [N2-1:0]    slot_ovf;
  logic [N2-1:0]    slot_pop;
  logic             pop;
  logic             at_last;

  assign at_last = (rd_ptr_q == LAST_IDX);
  assign pop     = slot_pend[rd_ptr_q] & out_ready_i;

  for (genvar k = 0; k < N2; k++) begin : g_slot
    assign slot_pop[k] = pop & (rd_ptr_q == IDX_W'(k));

    result_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .capture_i (finish_i[k]),
      .pop_i     (slot_pop[k]),
      .data_i    (pe_result_i[k*ACC_W +: ACC_W]),
      .data_o    (slot_data[k]),
      .pending_o (slot_pend[k]),
      .ovf_o     (slot_ovf[k])
    );
  end

  // Read pointer only advances on an accepted beat, which enforces in-order drain.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    tile_done_d = 1'b0;
    if (pop) begin
      rd_ptr_d    = at_last ? '0 : rd_ptr_q + IDX_W'(1);
      tile_done_d = at_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      tile_done_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign out_valid_o = slot_pend[rd_ptr_q];
  assign out_data_o  = slot_data[rd_ptr_q];
  assign out_idx_o   = rd_ptr_q;
  assign out_last_o  = slot_pend[rd_ptr_q] & at_last;
  assign tile_done_o = tile_done_q;
  assign overflow_o  = |slot_ovf;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios plus random traffic
// against a slot/queue reference model.
module tb_result_collector;
  import result_collector_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N2-1:0]       finish_i = '0;
  logic [N2*ACC_W-1:0] pe_res = '0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [ACC_W-1:0]    out_data;
  logic [IDX_W-1:0]    out_idx;
  logic                out_last;
  logic                tile_done;
  logic                overflow;

  result_collector dut (
    .clk         (clk),
    .rst         (rst),
    .finish_i    (finish_i),
    .pe_result_i (pe_res),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .tile_done_o (tile_done),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // reference model
  logic [ACC_W-1:0] m_val [N2];
  bit               m_pend [N2];
  int               m_rd;
  bit               m_ovf;
  bit               m_td;

  // beats observed on the stream, and tile_done pulses seen
  int               log_idx [$];
  logic [ACC_W-1:0] log_data [$];
  bit               log_last [$];
  int               td_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < int'(N2); k++) begin
      m_val[k]  = '0;
      m_pend[k] = 1'b0;
    end
    m_rd  = 0;
    m_ovf = 1'b0;
    m_td  = 1'b0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"},   64'(out_valid), 64'(m_pend[m_rd]));
    chk({tag, ".idx"},     64'(out_idx),   64'(m_rd));
    chk({tag, ".data"},    64'(out_data),  64'(m_val[m_rd]));
    chk({tag, ".last"},    64'(out_last),  64'(m_pend[m_rd] && m_rd == int'(N2) - 1));
    chk({tag, ".tdone"},   64'(tile_done), 64'(m_td));
    chk({tag, ".ovf"},     64'(overflow),  64'(m_ovf));
  endtask

  task automatic set_val(input int k, input logic [ACC_W-1:0] v);
    pe_res[k*ACC_W +: ACC_W] = v;
  endtask

  // One clock: drive inputs, advance model across the edge, compare after the edge.
  task automatic step(input logic [N2-1:0] f, input logic rdy, input string tag);
    bit pop;
    int p;
    finish_i  = f;
    out_ready = rdy;
    if (out_valid === 1'b1 && rdy) begin
      log_idx.push_back(int'(out_idx));
      log_data.push_back(out_data);
      log_last.push_back(out_last);
    end
    @(posedge clk);
    pop = m_pend[m_rd] && rdy;
    p   = m_rd;
    if (pop) begin
      m_pend[p] = 1'b0;
      m_rd      = (m_rd + 1) % int'(N2);
    end
    for (int k = 0; k < int'(N2); k++) begin
      if (f[k]) begin
        if (!m_pend[k]) begin
          m_val[k]  = pe_res[k*ACC_W +: ACC_W];
          m_pend[k] = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_td = pop && (p == int'(N2) - 1);
    #1;
    if (tile_done === 1'b1) td_count++;
    chk_all(tag);
    finish_i = '0;
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_data.delete();
    log_last.delete();
    td_count = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  // Wavefront finish pattern: anti-diagonal d = row+col finishes together.
  task automatic antidiag_tile(input int base, input string tag);
    logic [N2-1:0] f;
    clear_log();
    for (int d = 0; d < 2 * int'(ARRAY_SIZE) - 1; d++) begin
      f = '0;
      for (int k = 0; k < int'(N2); k++) begin
        if (k / int'(ARRAY_SIZE) + k % int'(ARRAY_SIZE) == d) begin
          f[k] = 1'b1;
          set_val(k, ACC_W'(base + k));
        end
      end
      step(f, 1'b1, tag);
    end
    for (int i = 0; i < 14; i++) step('0, 1'b1, tag);
    chk({tag, ".beats"}, 64'(log_idx.size()), 64'(N2));
    for (int i = 0; i < log_idx.size(); i++) begin
      chk({tag, ".bidx"},  64'(log_idx[i]),  64'(i));
      chk({tag, ".bdata"}, 64'(log_data[i]), 64'(base + i));
      chk({tag, ".blast"}, 64'(log_last[i]), 64'(i == int'(N2) - 1));
    end
    chk({tag, ".tdcnt"}, 64'(td_count), 64'd1);
  endtask

  initial begin
    logic [N2-1:0] f;

    // reset then idle
    do_reset("rst");
    for (int i = 0; i < 20; i++) step('0, 1'b1, "idle");
    chk("idle.idx", 64'(out_idx), 64'd0);

    // full tile in wavefront order
    antidiag_tile(100, "diag");

    // ordering: slot 5 must wait for 0..4
    do_reset("ord.rst");
    set_val(5, 32'hABCD);
    step(N2'(1) << 5, 1'b1, "ord.a");
    for (int i = 0; i < 4; i++) step('0, 1'b1, "ord.b");
    chk("ord.novalid", 64'(out_valid), 64'd0);
    chk("ord.nobeat", 64'(log_idx.size()), 64'd0);
    for (int k = 0; k < 5; k++) set_val(k, ACC_W'(200 + k));
    step(N2'(5'b11111), 1'b1, "ord.c");
    for (int i = 0; i < 8; i++) step('0, 1'b1, "ord.d");
    chk("ord.beats", 64'(log_idx.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_idx.size(); i++)
      chk("ord.bidx", 64'(log_idx[i]), 64'(i));
    if (log_data.size() >= 6) chk("ord.d5", 64'(log_data[5]), 64'hABCD);

    // backpressure holds slot 0 stable
    do_reset("bp.rst");
    set_val(0, 32'd7);
    step(N2'(1), 1'b0, "bp.fill");
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b0, "bp.hold");
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.data", 64'(out_data), 64'd7);
    end
    for (int i = 0; i < 4; i++) step('0, 1'b1, "bp.rel");
    chk("bp.beats", 64'(log_idx.size()), 64'd1);
    if (log_data.size() >= 1) chk("bp.bdata", 64'(log_data[0]), 64'd7);

    // overflow on slot 3
    do_reset("ovf.rst");
    set_val(3, 32'd1);
    step(N2'(1) << 3, 1'b0, "ovf.a");
    chk("ovf.clean", 64'(overflow), 64'd0);
    set_val(3, 32'd2);
    step(N2'(1) << 3, 1'b0, "ovf.b");
    chk("ovf.set", 64'(overflow), 64'd1);
    for (int k = 0; k < 3; k++) set_val(k, ACC_W'(k));
    step(N2'(3'b111), 1'b1, "ovf.c");
    for (int i = 0; i < 6; i++) step('0, 1'b1, "ovf.d");
    chk("ovf.beats", 64'(log_idx.size()), 64'd4);
    if (log_data.size() >= 4) chk("ovf.d3", 64'(log_data[3]), 64'd1);
    chk("ovf.sticky", 64'(overflow), 64'd1);

    // same-slot pop and refill
    do_reset("same.rst");
    set_val(0, 32'd5);
    step(N2'(1), 1'b0, "same.a");
    set_val(0, 32'd9);
    step(N2'(1), 1'b1, "same.b");
    chk("same.noovf", 64'(overflow), 64'd0);
    for (int k = 1; k < int'(N2); k++) set_val(k, ACC_W'(40 + k));
    f = '1;
    f[0] = 1'b0;
    step(f, 1'b1, "same.c");
    for (int i = 0; i < 18; i++) step('0, 1'b1, "same.d");
    chk("same.beats", 64'(log_idx.size()), 64'(N2 + 1));
    if (log_data.size() == N2 + 1) begin
      chk("same.first", 64'(log_data[0]), 64'd5);
      chk("same.idx0", 64'(log_idx[N2]), 64'd0);
      chk("same.refill", 64'(log_data[N2]), 64'd9);
    end
    chk("same.noovf2", 64'(overflow), 64'd0);

    // async reset mid-drain
    do_reset("ar.rst");
    for (int k = 0; k < int'(N2); k++) set_val(k, ACC_W'(300 + k));
    step('1, 1'b0, "ar.fill");
    for (int i = 0; i < 6; i++) step('0, 1'b1, "ar.drain");
    chk("ar.beats", 64'(log_idx.size()), 64'd6);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("ar.async");
    chk("ar.valid0", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    antidiag_tile(500, "ar.tile");

    // random traffic against the model
    do_reset("rnd.rst");
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < int'(N2); k++) set_val(k, ACC_W'($urandom));
      f = N2'($urandom & $urandom & $urandom);
      step(f, ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
